// File: rtl/mem_responder.sv
// Single-port memory responder: one-cycle writes, fixed-latency in-order reads,
// and a credit-limited FWFT response FIFO that absorbs response back-pressure.
module mem_responder #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 200,
    parameter int RD_LAT    = 2,
    parameter int RSP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int CNT_W  = $clog2(RSP_DEPTH + 1);
    localparam int PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic              rst_n_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              accept;
    logic              rd_acc;
    logic              wr_acc;
    logic              in_range;
    logic [MEM_AW-1:0] mem_idx;
    logic              push;
    logic              push_err;
    logic [DATA_W-1:0] push_data;
    logic              pop;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    assign req_ready = rst_n_reg && (cnt_reg < CNT_W'(RSP_DEPTH));
    assign accept    = req_valid && req_ready;
    assign rd_acc    = accept && !req_we;
    assign wr_acc    = accept && req_we;
    assign in_range  = (32'(req_addr) < 32'(MEM_DEPTH));
    assign mem_idx   = req_addr[MEM_AW-1:0];

    always_ff @(posedge clk) begin
        rst_n_reg <= rst_n;
    end

    // Memory has no reset; out-of-range writes are simply not performed.
    always_ff @(posedge clk) begin
        if (wr_acc && in_range) begin
            mem[mem_idx] <= req_wdata;
        end
    end

    // Credits cover every read from acceptance until its response is popped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            case ({rd_acc, pop})
                2'b10:   cnt_reg <= cnt_reg + 1'b1;
                2'b01:   cnt_reg <= cnt_reg - 1'b1;
                default: cnt_reg <= cnt_reg;
            endcase
        end
    end

    generate
        if (RD_LAT == 1) begin : g_direct
            assign push      = rd_acc;
            assign push_err  = !in_range;
            assign push_data = in_range ? mem[mem_idx] : '0;
        end else begin : g_pipe
            for (genvar gi = 0; gi < RD_LAT - 1; gi++) begin : g_stage
                logic              valid_reg;
                logic              err_reg;
                logic [DATA_W-1:0] data_reg;
                if (gi == 0) begin : g_head
                    // Registered array read: this stage is the block-RAM output register.
                    always_ff @(posedge clk) begin
                        if (!rst_n) begin
                            valid_reg <= 1'b0;
                        end else begin
                            valid_reg <= rd_acc;
                        end
                        if (rd_acc) begin
                            err_reg  <= !in_range;
                            data_reg <= mem[mem_idx];
                        end
                    end
                end else begin : g_tail
                    always_ff @(posedge clk) begin
                        if (!rst_n) begin
                            valid_reg <= 1'b0;
                        end else begin
                            valid_reg <= g_stage[gi-1].valid_reg;
                        end
                        err_reg  <= g_stage[gi-1].err_reg;
                        data_reg <= g_stage[gi-1].data_reg;
                    end
                end
            end
            assign push      = g_stage[RD_LAT-2].valid_reg;
            assign push_err  = g_stage[RD_LAT-2].err_reg;
            assign push_data = push_err ? '0 : g_stage[RD_LAT-2].data_reg;
        end
    endgenerate

    logic [DATA_W:0]  fifo_mem [RSP_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] fill_reg;
    logic [DATA_W:0]  head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop = rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            fill_reg   <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr_reg] <= {push_err, push_data};
                wr_ptr_reg           <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({push, pop})
                2'b10:   fill_reg <= fill_reg + 1'b1;
                2'b01:   fill_reg <= fill_reg - 1'b1;
                default: fill_reg <= fill_reg;
            endcase
        end
    end

    // Head is masked so a drained FIFO never exposes stale data on the outputs.
    assign head      = fifo_mem[rd_ptr_reg];
    assign rsp_valid = (fill_reg != '0);
    assign rsp_rdata = rsp_valid ? head[DATA_W-1:0] : '0;
    assign rsp_err   = rsp_valid && head[DATA_W];

    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (fill_reg == CNT_W'(RSP_DEPTH))));

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a plain array/queue memory model predicts every
// read response; a monitor pops predictions whenever a response is consumed.
module tb_mem_responder;

    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 32;
    localparam int MEM_DEPTH = 200;
    localparam int RD_LAT    = 2;
    localparam int RSP_DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    mem_responder #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH),
        .RD_LAT(RD_LAT), .RSP_DEPTH(RSP_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle++;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: word array plus queue of predicted responses.
    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic [DATA_W-1:0] model_mem [256];
    exp_t              exp_q[$];
    int                pop_cycles[$];

    task automatic model_accept(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        exp_t e;
        if (we) begin
            if (int'(a) < MEM_DEPTH) model_mem[a] = d;
        end else begin
            e.err  = (int'(a) >= MEM_DEPTH);
            e.data = e.err ? '0 : model_mem[a];
            exp_q.push_back(e);
        end
    endtask

    // rsp_mode: 0 = hold off, 1 = always ready, 2 = random back-pressure
    int rsp_mode = 1;
    always @(posedge clk) begin
        #2;
        if (rsp_mode == 2) rsp_ready = ($urandom % 4) != 0;
        else rsp_ready = (rsp_mode == 1);
    end

    // Monitor: compares consumed responses and checks hold stability under back-pressure.
    logic              held_v = 1'b0;
    logic [DATA_W-1:0] held_d;
    logic              held_e;
    exp_t              mon_e;
    int                rsp_n = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                chk("hold_valid", rsp_valid, 1);
                chk("hold_data", rsp_rdata, held_d);
                chk("hold_err", rsp_err, held_e);
            end
            held_v = 1'b0;
            if (rsp_valid && rsp_ready) begin
                chk("rsp_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("rsp_err", rsp_err, mon_e.err);
                    chk("rsp_data", rsp_rdata, mon_e.data);
                    pop_cycles.push_back(cycle);
                    $display("rsp %0d: data=%08h err=%0b (cycle %0d)", rsp_n, rsp_rdata, rsp_err, cycle);
                    rsp_n++;
                end
            end else if (rsp_valid) begin
                held_v = 1'b1;
                held_d = rsp_rdata;
                held_e = rsp_err;
            end
        end
    end

    task automatic drive(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, output bit acc);
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
        acc = req_ready;
        if (acc) model_accept(we, a, d);
    endtask

    task automatic drive_retry(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bit acc = 1'b0;
        for (int t = 0; t < 100 && !acc; t++) drive(we, a, d, acc);
        if (!acc) chk("accept_timeout", acc, 1);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(negedge clk);
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit hit, %0d/%0d so far", passed, checks);
        $fatal(1);
    end

    initial begin
        bit acc;
        int n_acc;

        // Reset behaviour
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_req_ready", req_ready, 0);
        end
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rel_req_ready", req_ready, 1);

        // Read-after-write and latency
        drive_retry(1'b1, 8'h10, 32'hDEADBEEF);
        drive(1'b0, 8'h10, '0, acc);
        chk("raw_accept", acc, 1);
        idle();
        for (int k = 1; k < RD_LAT; k++) begin
            @(negedge clk);
            chk("raw_lat_early", rsp_valid, 0);
        end
        @(negedge clk);
        chk("raw_lat_on", rsp_valid, 1);
        drain();

        // Streaming back-to-back reads
        for (int a = 0; a < 16; a++) drive_retry(1'b1, ADDR_W'(a), DATA_W'(a * 3));
        pop_cycles.delete();
        for (int a = 0; a < 16; a++) begin
            drive(1'b0, ADDR_W'(a), '0, acc);
            chk("stream_ready", acc, 1);
        end
        idle();
        drain();
        chk("stream_count", pop_cycles.size(), 16);
        if (pop_cycles.size() == 16) chk("stream_consec", pop_cycles[15] - pop_cycles[0], 15);

        // Back-pressure: credits stop acceptance at RSP_DEPTH
        rsp_mode = 0;
        idle();
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, ADDR_W'(i), '0, acc);
            if (acc) n_acc++;
        end
        chk("bp_accepted", n_acc, RSP_DEPTH);
        chk("bp_ready_low", req_ready, 0);
        chk("bp_no_pop", exp_q.size(), RSP_DEPTH);
        @(posedge clk);
        #1 rsp_mode = 1;
        drive_retry(1'b0, 8'd4, '0);
        drive_retry(1'b0, 8'd5, '0);
        idle();
        drain();

        // Range handling
        drive_retry(1'b1, 8'd199, 32'h12345678);
        drive_retry(1'b1, 8'd200, 32'h00000055);
        drive_retry(1'b0, 8'd200, '0);
        drive_retry(1'b0, 8'd199, '0);
        drive_retry(1'b0, 8'd255, '0);
        idle();
        drain();

        // Mid-operation reset drops in-flight reads
        rsp_mode = 0;
        for (int i = 0; i < 3; i++) drive_retry(1'b0, ADDR_W'(i), '0);
        idle();
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        rsp_mode = 1;
        repeat (5) begin
            @(negedge clk);
            chk("post_rst_valid", rsp_valid, 0);
        end
        rsp_mode = 0;
        idle();
        n_acc = 0;
        for (int i = 0; i < RSP_DEPTH; i++) begin
            drive(1'b0, ADDR_W'(i + 7), '0, acc);
            if (acc) n_acc++;
        end
        chk("post_rst_credits", n_acc, RSP_DEPTH);
        idle();
        @(posedge clk);
        #1 rsp_mode = 1;
        drain();

        // Randomised traffic over a fully initialised memory
        for (int a = 0; a < MEM_DEPTH; a++) drive_retry(1'b1, ADDR_W'(a), $urandom);
        idle();
        rsp_mode = 2;
        for (int n = 0; n < 400; n++) begin
            drive_retry(($urandom % 3) == 0, ADDR_W'($urandom_range(0, 219)), $urandom);
            if (($urandom % 8) == 0) idle();
        end
        idle();
        rsp_mode = 1;
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
